// File: rtl/matrix_alu_sequencer_pkg.sv
// Shared constants, command payload and helpers for the matrix ALU host sequencer.
// Elements are packed row-major with a fixed DIM stride regardless of the active size.
package matrix_alu_sequencer_pkg;

    localparam int unsigned DIM     = 5;
    localparam int unsigned W       = 8;
    localparam int unsigned FLAT_W  = DIM * DIM * W;
    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned DIM_W   = 3;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned TCNT_W  = 10;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_NEG   = 3'b100;
    localparam logic [2:0] OP_TRANS = 3'b101;
    localparam logic [2:0] OP_SCAL  = 3'b110;
    localparam logic [2:0] OP_DET   = 3'b111;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_STREAM = 3'd5;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] size;
        logic [7:0] scalar;
    } cmd_t;

    // Only the element-wise binary ops and the product consume a second operand.
    function automatic logic needs_b(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    function automatic logic cmd_ok(input logic [2:0] op, input logic [2:0] size);
        return (op != OP_NONE) && (size >= 3'd2) && (size <= 3'd5);
    endfunction

    function automatic logic [IDX_W-1:0] byte_offset(input logic [DIM_W-1:0] r,
                                                     input logic [DIM_W-1:0] c);
        return IDX_W'(int'(r) * int'(DIM) + int'(c));
    endfunction

endpackage

// File: rtl/matrix_alu_sequencer_walker.sv
// Row-major walker over the active n x n window; reports element slot of the
// current and the following position, plus last / second-to-last flags.
module matrix_alu_sequencer_walker
    import matrix_alu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] n,
    output logic             last_c,
    output logic             penult_c,
    output logic [IDX_W-1:0] offset_c,
    output logic [IDX_W-1:0] next_offset_c
);

    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row_nxt;
    logic [DIM_W-1:0] col_nxt;
    logic [DIM_W-1:0] n_m1;
    logic [DIM_W-1:0] n_m2;

    assign n_m1 = n - DIM_W'(1);
    assign n_m2 = n - DIM_W'(2);

    always_comb begin
        row_nxt = row;
        col_nxt = col + DIM_W'(1);
        if (col == n_m1) begin
            row_nxt = row + DIM_W'(1);
            col_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

    assign last_c        = (row == n_m1) && (col == n_m1);
    assign penult_c      = (row == n_m1) && (col == n_m2);
    assign offset_c      = byte_offset(row, col);
    assign next_offset_c = byte_offset(row_nxt, col_nxt);

endmodule

// File: rtl/matrix_alu_sequencer.sv
// Host-side sequencer for the 5x5 int8 matrix ALU: loads operands over a byte
// port, launches the opcode, waits for done (or timeout), streams the result.
module matrix_alu_sequencer
    import matrix_alu_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        cmd_opcode,
    input  logic [2:0]        cmd_size,
    input  logic [7:0]        cmd_scalar,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              done,
    output logic              ovf,
    output logic              err_cmd,
    output logic              err_timeout,
    output logic [FLAT_W-1:0] alu_a_flat,
    output logic [FLAT_W-1:0] alu_b_flat,
    output logic [7:0]        alu_f,
    output logic [2:0]        alu_opcode,
    input  logic [FLAT_W-1:0] alu_c_flat,
    input  logic              alu_overflow,
    input  logic              alu_done
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [2:0]        op_q;
    logic [DIM_W-1:0]  n_q;
    logic [FLAT_W-1:0] res_q;
    logic [TCNT_W-1:0] tcnt;

    cmd_t              cmd_c;
    logic              cmd_ok_c;
    logic              accept_c;
    logic              in_acc_c;
    logic              out_acc_c;
    logic              stream_last_c;
    logic              walk_clear_c;
    logic              walk_adv_c;
    logic              capture_c;
    logic              timeout_hit_c;
    logic              walk_last_c;
    logic              walk_penult_c;
    logic [IDX_W-1:0]  walk_offset_c;
    logic [IDX_W-1:0]  walk_next_offset_c;

    assign cmd_c         = '{opcode: cmd_opcode, size: cmd_size, scalar: cmd_scalar};
    assign cmd_ok_c      = cmd_ok(cmd_c.opcode, cmd_c.size);
    assign accept_c      = (state == S_IDLE) && start && cmd_ok_c;
    assign in_acc_c      = in_valid && in_ready;
    assign out_acc_c     = out_valid && out_ready;
    // Determinant results are a single scalar in the low byte.
    assign stream_last_c = (op_q == OP_DET) || walk_last_c;

    matrix_alu_sequencer_walker u_walker (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (walk_clear_c),
        .advance       (walk_adv_c),
        .n             (n_q),
        .last_c        (walk_last_c),
        .penult_c      (walk_penult_c),
        .offset_c      (walk_offset_c),
        .next_offset_c (walk_next_offset_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and walker control; the walker restarts on every loading/streaming phase.
    always_comb begin
        state_nxt     = state;
        walk_clear_c  = 1'b0;
        walk_adv_c    = 1'b0;
        capture_c     = 1'b0;
        timeout_hit_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_nxt    = S_LOAD_A;
                    walk_clear_c = 1'b1;
                end
            end
            S_LOAD_A: begin
                if (in_acc_c) begin
                    walk_adv_c = 1'b1;
                    if (walk_last_c) begin
                        walk_clear_c = 1'b1;
                        state_nxt    = needs_b(op_q) ? S_LOAD_B : S_EXEC;
                    end
                end
            end
            S_LOAD_B: begin
                if (in_acc_c) begin
                    walk_adv_c = 1'b1;
                    if (walk_last_c) begin
                        walk_clear_c = 1'b1;
                        state_nxt    = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    capture_c    = 1'b1;
                    walk_clear_c = 1'b1;
                    state_nxt    = S_STREAM;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    capture_c     = 1'b1;
                    timeout_hit_c = 1'b1;
                    walk_clear_c  = 1'b1;
                    state_nxt     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_acc_c) begin
                    walk_adv_c = 1'b1;
                    if (stream_last_c) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand/result registers, status flags and registered host-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= OP_NONE;
            n_q         <= '0;
            res_q       <= '0;
            tcnt        <= '0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
            alu_a_flat  <= '0;
            alu_b_flat  <= '0;
            alu_f       <= '0;
            alu_opcode  <= OP_NONE;
        end else begin
            busy       <= (state_nxt != S_IDLE);
            in_ready   <= (state_nxt == S_LOAD_A) || (state_nxt == S_LOAD_B);
            alu_opcode <= ((state_nxt == S_EXEC) || (state_nxt == S_WAIT)) ? op_q : OP_NONE;
            err_cmd    <= (state == S_IDLE) && start && !cmd_ok_c;
            done       <= (state == S_STREAM) && out_acc_c && stream_last_c;
            tcnt       <= (state == S_WAIT) ? tcnt + TCNT_W'(1) : '0;

            if (accept_c) begin
                op_q        <= cmd_c.opcode;
                n_q         <= cmd_c.size;
                alu_f       <= cmd_c.scalar;
                alu_a_flat  <= '0;
                alu_b_flat  <= '0;
                ovf         <= 1'b0;
                err_timeout <= 1'b0;
            end

            if ((state == S_LOAD_A) && in_acc_c) begin
                alu_a_flat[int'(walk_offset_c) * W +: W] <= in_data;
            end
            if ((state == S_LOAD_B) && in_acc_c) begin
                alu_b_flat[int'(walk_offset_c) * W +: W] <= in_data;
            end

            // First result byte is taken straight from the bus while it is being captured.
            if (capture_c) begin
                res_q     <= alu_c_flat;
                ovf       <= alu_overflow;
                out_valid <= 1'b1;
                out_data  <= alu_c_flat[W-1:0];
                out_last  <= (op_q == OP_DET);
                if (timeout_hit_c) begin
                    err_timeout <= 1'b1;
                end
            end else if ((state == S_STREAM) && out_acc_c) begin
                if (stream_last_c) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_last  <= 1'b0;
                end else begin
                    out_data <= res_q[int'(walk_next_offset_c) * W +: W];
                    out_last <= walk_penult_c;
                end
            end
        end
    end

endmodule
